rc4_key_search_ctrl: RTL and testbench
======================================

// Module: rc4_key_search_ctrl
// PURPOSE
//  Top-level sequencer for RC4 key search. Per candidate key it runs S-init (s[i]=i), then KSA, then PRGA/decrypt.
//  Owns the single S-memory port and the decrypted-message RAM port and muxes them to the active phase.
//  Scans the 32-byte decrypted message for printable text; on failure it increments the key and retries.
//  Sits between the top-level/board glue and the init, KSA and PRGA engines.
// PARAMETERS
//  KEY_W     24         candidate key width (key_out bits)
//  KEY_MAX   24'h3FFFFF last key tried before declaring failure
//  MSG_LEN   32         decrypted message length in bytes (address width 5)
//  READ_WAIT 3          cycles between driving a RAM address and sampling q
// PORTS
//  clk            in  1   clock
//  reset          in  1   synchronous, active-high
//  start          in  1   pulse: begin search at key 0 (accepted in IDLE, FOUND or FAIL only)
//  init_start, ksa_start, prga_start  out 1 each  phase enables, held high for the whole phase
//  init_done, ksa_done, prga_done     in  1 each  sticky done flags from the engines
//  sub_reset      out 1   one-cycle reset pulse to all engines before each key
//  key_out        out KEY_W  current/final candidate key
//  init_s_addr/data/wren, ksa_s_addr/data/wren, prga_s_addr/data/wren  in 8/8/1  engine S requests
//  s_address, s_data  out 8 each; s_wren out 1  muxed S-memory port
//  prga_dm_addr in 5, prga_dm_data in 8, prga_dm_wren in 1  PRGA decrypted-RAM writes
//  dm_address out 5, dm_data out 8, dm_wren out 1, dm_q in 8  muxed decrypted-RAM port
//  busy, found, failed  out 1 each  status
// BEHAVIOUR
//  Reset: all outputs 0, key_out=0, state IDLE. Takes effect on any cycle, including mid-phase; engines stop.
//  State flow: IDLE -start-> SUB_RST -> INIT -> KSA -> PRGA -> CHK_ADDR -> CHK_WAIT -> CHK_EVAL -> NEXT_KEY/FOUND.
//  IDLE: busy=0; on start, key_out=0, found=failed=0, go to SUB_RST.
//  SUB_RST: sub_reset=1 for exactly 1 cycle; busy=1.
//  INIT/KSA/PRGA: the matching *_start is 1. When the matching *_done is sampled 1: drop *_start and advance.
//    Each done is honoured only in its own phase.
//  S mux: the owner is registered from the state.
//    INIT->init_*, KSA->ksa_*, PRGA->prga_*; any other state: s_wren=0, s_address=s_data=0.
//    The mux is combinational from the owner and inputs, so there is no added latency.
//    Inputs from non-owners are ignored, even with wren=1.
//  DM mux: in PRGA, dm_* = prga_dm_*. In CHK_*, dm_address=chk_idx and dm_wren=0. Otherwise all 0.
//  CHK_ADDR: drive chk_idx (5b, starts 0), then hold it READ_WAIT cycles in CHK_WAIT.
//  CHK_EVAL samples dm_q. A byte is valid iff 8'h61<=q<=8'h7A or q==8'h20.
//   invalid -> NEXT_KEY
//   valid, chk_idx==MSG_LEN-1 -> FOUND
//   else chk_idx+1 -> CHK_ADDR
//  NEXT_KEY:
//   if key_out==KEY_MAX -> FAIL, key_out held
//   else key_out+1, chk_idx=0 -> SUB_RST
//  key_out never wraps.
//  FOUND: found=1, busy=0, key_out frozen. FAIL: failed=1, busy=0. Both hold until reset or start.
//  start while busy=1 is ignored. start and reset together: reset wins.
//  Per-byte check cost: 1 + READ_WAIT + 1 cycles. Exactly one sub_reset pulse per key attempted.
// TESTING
//  1 Engine models respond; key 0 decrypts all bytes to 0x61
//    -> found=1, key_out=0, one sub_reset pulse, failed=0.
//  2 Byte 31 invalid (0x7B) for keys 0-2, all valid at key 3
//    -> found=1, key_out=3, four sub_reset pulses total.
//  3 KEY_MAX=3, byte 0 always 0x00
//    -> failed=1, found=0, key_out=3, busy=0, no fifth attempt.
//  4 In KSA, ksa_s_wren=1 addr 0x10 data 0xAB with init_s_wren=1 addr 0x05
//    -> s_wren=1, s_address=0x10, s_data=0xAB; in CHK_* s_wren=0.
//  5 Byte boundaries 0x60, 0x7B, 0x1F, 0x21 rejected; 0x61, 0x7A, 0x20 accepted, each as byte 0 and byte 31.
//  6 reset asserted mid-PRGA, then start
//    -> next cycle all *_start=0, s_wren=0, dm_wren=0, key_out=0;
//       restart runs a clean SUB_RST, INIT sequence.

Source files
------------

// File: rtl/rc4_key_search_if.sv
// Handshake and memory-port bundle between the RC4 key-search sequencer and its
// surroundings (init/KSA/PRGA engines, S-memory, decrypted-message RAM, board glue).
interface rc4_key_search_if #(
  parameter int KEY_W = 24
);
  logic             start;
  logic             init_start, ksa_start, prga_start;
  logic             init_done, ksa_done, prga_done;
  logic             sub_reset;
  logic [KEY_W-1:0] key_out;
  logic [7:0]       init_s_addr, init_s_data;
  logic             init_s_wren;
  logic [7:0]       ksa_s_addr, ksa_s_data;
  logic             ksa_s_wren;
  logic [7:0]       prga_s_addr, prga_s_data;
  logic             prga_s_wren;
  logic [7:0]       s_address, s_data;
  logic             s_wren;
  logic [4:0]       prga_dm_addr;
  logic [7:0]       prga_dm_data;
  logic             prga_dm_wren;
  logic [4:0]       dm_address;
  logic [7:0]       dm_data;
  logic             dm_wren;
  logic [7:0]       dm_q;
  logic             busy, found, failed;

  modport master (
    input  start, init_done, ksa_done, prga_done,
           init_s_addr, init_s_data, init_s_wren,
           ksa_s_addr, ksa_s_data, ksa_s_wren,
           prga_s_addr, prga_s_data, prga_s_wren,
           prga_dm_addr, prga_dm_data, prga_dm_wren, dm_q,
    output init_start, ksa_start, prga_start, sub_reset, key_out,
           s_address, s_data, s_wren,
           dm_address, dm_data, dm_wren,
           busy, found, failed
  );

  modport slave (
    output start, init_done, ksa_done, prga_done,
           init_s_addr, init_s_data, init_s_wren,
           ksa_s_addr, ksa_s_data, ksa_s_wren,
           prga_s_addr, prga_s_data, prga_s_wren,
           prga_dm_addr, prga_dm_data, prga_dm_wren, dm_q,
    input  init_start, ksa_start, prga_start, sub_reset, key_out,
           s_address, s_data, s_wren,
           dm_address, dm_data, dm_wren,
           busy, found, failed
  );
endinterface

// File: rtl/rc4_key_search_ctrl.sv
// RC4 key-search sequencer: per candidate key runs S-init, KSA and PRGA, then scans
// the decrypted message for lowercase/space text and advances the key on failure.
module rc4_key_search_ctrl #(
  parameter int               KEY_W     = 24,
  parameter logic [KEY_W-1:0] KEY_MAX   = 'h3FFFFF,
  parameter int               MSG_LEN   = 32,
  parameter int               READ_WAIT = 3
) (
  input logic               clk,
  input logic               reset,
  rc4_key_search_if.master  bus
);

  localparam int IDX_W  = 5;
  localparam int WAIT_W = $clog2(READ_WAIT + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(MSG_LEN - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(READ_WAIT - 1);

  typedef enum logic [3:0] {
    IDLE, SUB_RST, INIT, KSA, PRGA, CHK_ADDR, CHK_WAIT, CHK_EVAL, NEXT_KEY, FOUND, FAIL
  } state_t;

  typedef enum logic [1:0] {OWN_NONE, OWN_INIT, OWN_KSA, OWN_PRGA} owner_t;

  state_t             state_q, state_d;
  owner_t             owner_q, owner_d;
  logic [KEY_W-1:0]   key_q, key_d;
  logic [IDX_W-1:0]   chk_q, chk_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;

  logic init_start, ksa_start, prga_start, sub_reset, busy, found, failed;

  function automatic logic byte_valid(input logic [7:0] q);
    return ((q >= 8'h61) && (q <= 8'h7A)) || (q == 8'h20);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= OWN_NONE;
      key_q   <= '0;
      chk_q   <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      key_q   <= key_d;
      chk_q   <= chk_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    chk_d      = chk_q;
    wait_d     = wait_q;
    init_start = 1'b0;
    ksa_start  = 1'b0;
    prga_start = 1'b0;
    sub_reset  = 1'b0;
    busy       = 1'b1;
    found      = 1'b0;
    failed     = 1'b0;
    unique case (state_q)
      IDLE, FOUND, FAIL: begin
        busy   = 1'b0;
        found  = (state_q == FOUND);
        failed = (state_q == FAIL);
        if (bus.start) begin
          key_d   = '0;
          chk_d   = '0;
          state_d = SUB_RST;
        end
      end
      SUB_RST: begin
        sub_reset = 1'b1;
        state_d   = INIT;
      end
      INIT: begin
        init_start = 1'b1;
        if (bus.init_done) state_d = KSA;
      end
      KSA: begin
        ksa_start = 1'b1;
        if (bus.ksa_done) state_d = PRGA;
      end
      PRGA: begin
        prga_start = 1'b1;
        if (bus.prga_done) state_d = CHK_ADDR;
      end
      CHK_ADDR: begin
        wait_d  = '0;
        state_d = CHK_WAIT;
      end
      CHK_WAIT: begin
        if (wait_q == WAIT_LAST) state_d = CHK_EVAL;
        else                     wait_d  = wait_q + 1'b1;
      end
      CHK_EVAL: begin
        if (!byte_valid(bus.dm_q)) begin
          state_d = NEXT_KEY;
        end else if (chk_q == LAST_IDX) begin
          state_d = FOUND;
        end else begin
          chk_d   = chk_q + 1'b1;
          state_d = CHK_ADDR;
        end
      end
      NEXT_KEY: begin
        // Stop at KEY_MAX rather than wrapping back to key 0.
        if (key_q == KEY_MAX) begin
          state_d = FAIL;
        end else begin
          key_d   = key_q + 1'b1;
          chk_d   = '0;
          state_d = SUB_RST;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Owner tracks the next state so the S port follows the phase with no lag.
  always_comb begin
    unique case (state_d)
      INIT:    owner_d = OWN_INIT;
      KSA:     owner_d = OWN_KSA;
      PRGA:    owner_d = OWN_PRGA;
      default: owner_d = OWN_NONE;
    endcase
  end

  always_comb begin
    bus.s_address = 8'h00;
    bus.s_data    = 8'h00;
    bus.s_wren    = 1'b0;
    unique case (owner_q)
      OWN_INIT: begin
        bus.s_address = bus.init_s_addr;
        bus.s_data    = bus.init_s_data;
        bus.s_wren    = bus.init_s_wren;
      end
      OWN_KSA: begin
        bus.s_address = bus.ksa_s_addr;
        bus.s_data    = bus.ksa_s_data;
        bus.s_wren    = bus.ksa_s_wren;
      end
      OWN_PRGA: begin
        bus.s_address = bus.prga_s_addr;
        bus.s_data    = bus.prga_s_data;
        bus.s_wren    = bus.prga_s_wren;
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.dm_address = 5'd0;
    bus.dm_data    = 8'h00;
    bus.dm_wren    = 1'b0;
    if (state_q == PRGA) begin
      bus.dm_address = bus.prga_dm_addr;
      bus.dm_data    = bus.prga_dm_data;
      bus.dm_wren    = bus.prga_dm_wren;
    end else if ((state_q == CHK_ADDR) || (state_q == CHK_WAIT) || (state_q == CHK_EVAL)) begin
      bus.dm_address = chk_q;
    end
  end

  assign bus.init_start = init_start;
  assign bus.ksa_start  = ksa_start;
  assign bus.prga_start = prga_start;
  assign bus.sub_reset  = sub_reset;
  assign bus.key_out    = key_q;
  assign bus.busy       = busy;
  assign bus.found      = found;
  assign bus.failed     = failed;

endmodule

// File: tb/tb_rc4_key_search_ctrl.sv
// Bench for rc4_key_search_ctrl: behavioural engines and message RAM around the
// sequencer, with a queue of expected search outcomes checked as each search ends.
module tb_rc4_key_search_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rc4_key_search_if #(.KEY_W(24)) bus();

  rc4_key_search_ctrl #(
    .KEY_W(24), .KEY_MAX(24'd3), .MSG_LEN(32), .READ_WAIT(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    logic        found;
    logic        failed;
    logic [23:0] key;
    int          sr;
  } exp_t;

  exp_t sb[$];
  int   nchk = 0;
  int   nfail = 0;
  int   sr_cnt = 0;
  int   mode = 0;
  int   bpos = 0;
  logic [7:0] bval = 8'h61;

  // Message content the PRGA model writes for a given key and byte index.
  function automatic logic [7:0] pattern(input logic [23:0] key, input int idx);
    case (mode)
      0:       return 8'h61;
      1:       return (idx == 31 && key < 24'd3) ? 8'h7B : 8'h61;
      2:       return (idx == 0) ? 8'h00 : 8'h61;
      default: return (key == 24'd0 && idx == bpos) ? bval : 8'h61;
    endcase
  endfunction

  logic [7:0] mem [32];
  int icnt, kcnt, pidx;

  always @(posedge clk) begin
    if (bus.sub_reset) sr_cnt <= sr_cnt + 1;
    if (bus.dm_wren) mem[bus.dm_address] <= bus.dm_data;
    bus.dm_q <= mem[bus.dm_address];
    if (reset || bus.sub_reset) begin
      bus.init_done    <= 1'b0;
      bus.ksa_done     <= 1'b0;
      bus.prga_done    <= 1'b0;
      bus.prga_dm_wren <= 1'b0;
      bus.prga_dm_addr <= 5'd0;
      bus.prga_dm_data <= 8'h00;
      icnt <= 0;
      kcnt <= 0;
      pidx <= 0;
    end else begin
      if (bus.init_start && !bus.init_done) begin
        if (icnt == 3) bus.init_done <= 1'b1;
        else           icnt <= icnt + 1;
      end
      if (bus.ksa_start && !bus.ksa_done) begin
        if (kcnt == 6) bus.ksa_done <= 1'b1;
        else           kcnt <= kcnt + 1;
      end
      if (bus.prga_start && !bus.prga_done) begin
        if (pidx == 32) begin
          bus.prga_dm_wren <= 1'b0;
          bus.prga_done    <= 1'b1;
        end else begin
          bus.prga_dm_wren <= 1'b1;
          bus.prga_dm_addr <= pidx[4:0];
          bus.prga_dm_data <= pattern(bus.key_out, pidx);
          pidx <= pidx + 1;
        end
      end
    end
  end

  function automatic logic cond(input int which);
    case (which)
      0:       return bus.init_start;
      1:       return bus.ksa_start;
      2:       return bus.prga_start;
      3:       return bus.busy && !bus.init_start && !bus.ksa_start && !bus.prga_start && !bus.sub_reset;
      default: return bus.prga_start && (bus.key_out == 24'd2);
    endcase
  endfunction

  task automatic wait_cond(input int which, input string name, output bit ok);
    int n = 0;
    while (!cond(which) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    ok = cond(which);
    if (!ok) begin
      nchk++;
      nfail++;
      $display("FAIL %s: timed out waiting, condition=%0d required=1", name, ok);
    end
  endtask

  task automatic start_pulse();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic push_exp(input logic f, input logic fl, input logic [23:0] key, input int n);
    exp_t e;
    e.found  = f;
    e.failed = fl;
    e.key    = key;
    e.sr     = sr_cnt + n;
    sb.push_back(e);
  endtask

  task automatic wait_result(input string name);
    exp_t e;
    int n = 0;
    while (!(bus.found || bus.failed) && n < 6000) begin
      @(negedge clk);
      n++;
    end
    e = sb.pop_front();
    nchk++;
    if (!(bus.found || bus.failed)) begin
      nfail++;
      $display("FAIL %s_timeout: found=%0b failed=%0b, required an outcome", name, bus.found, bus.failed);
      return;
    end
    if (bus.found !== e.found) begin
      nfail++;
      $display("FAIL %s_found: got %0b required %0b", name, bus.found, e.found);
    end
    nchk++;
    if (bus.failed !== e.failed) begin
      nfail++;
      $display("FAIL %s_failed: got %0b required %0b", name, bus.failed, e.failed);
    end
    nchk++;
    if (bus.key_out !== e.key) begin
      nfail++;
      $display("FAIL %s_key: got %0h required %0h", name, bus.key_out, e.key);
    end
    nchk++;
    if (sr_cnt !== e.sr) begin
      nfail++;
      $display("FAIL %s_subresets: got %0d required %0d", name, sr_cnt, e.sr);
    end
    nchk++;
    if (bus.busy !== 1'b0) begin
      nfail++;
      $display("FAIL %s_busy: got %0b required 0", name, bus.busy);
    end
  endtask

  task automatic run_search(input string name, input logic f, input logic fl,
                            input logic [23:0] key, input int n);
    push_exp(f, fl, key, n);
    start_pulse();
    wait_result(name);
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    nchk++;
    if ({bus.init_start, bus.ksa_start, bus.prga_start, bus.sub_reset, bus.busy,
         bus.found, bus.failed, bus.s_wren, bus.dm_wren} !== 9'b0) begin
      nfail++;
      $display("FAIL reset_ctrl: got %b required 000000000",
               {bus.init_start, bus.ksa_start, bus.prga_start, bus.sub_reset, bus.busy,
                bus.found, bus.failed, bus.s_wren, bus.dm_wren});
    end
    nchk++;
    if (bus.key_out !== 24'd0) begin
      nfail++;
      $display("FAIL reset_key: got %0h required 0", bus.key_out);
    end
    nchk++;
    if ({bus.s_address, bus.s_data, bus.dm_address, bus.dm_data} !== 29'd0) begin
      nfail++;
      $display("FAIL reset_ports: s_addr=%0h s_data=%0h dm_addr=%0h dm_data=%0h required 0",
               bus.s_address, bus.s_data, bus.dm_address, bus.dm_data);
    end
    reset = 1'b0;
  endtask

  task automatic test_key0();
    mode = 0;
    run_search("key0", 1'b1, 1'b0, 24'd0, 1);
  endtask

  task automatic test_retry();
    mode = 1;
    run_search("retry", 1'b1, 1'b0, 24'd3, 4);
  endtask

  task automatic test_fail();
    int s;
    mode = 2;
    run_search("fail", 1'b0, 1'b1, 24'd3, 4);
    s = sr_cnt;
    repeat (40) @(negedge clk);
    nchk++;
    if (sr_cnt !== s) begin
      nfail++;
      $display("FAIL fail_no_retry: subresets %0d required %0d", sr_cnt, s);
    end
    nchk++;
    if ({bus.failed, bus.busy, bus.found} !== 3'b100) begin
      nfail++;
      $display("FAIL fail_hold: failed/busy/found=%b required 100", {bus.failed, bus.busy, bus.found});
    end
  endtask

  task automatic test_s_mux();
    bit ok;
    mode = 0;
    push_exp(1'b1, 1'b0, 24'd0, 1);
    start_pulse();
    wait_cond(0, "smux_wait_init", ok);
    if (ok) begin
      nchk++;
      if ({bus.s_wren, bus.s_address, bus.s_data} !== {1'b1, 8'h05, 8'h11}) begin
        nfail++;
        $display("FAIL smux_init: wren=%0b addr=%0h data=%0h required 1/05/11",
                 bus.s_wren, bus.s_address, bus.s_data);
      end
    end
    wait_cond(1, "smux_wait_ksa", ok);
    if (ok) begin
      nchk++;
      if ({bus.s_wren, bus.s_address, bus.s_data} !== {1'b1, 8'h10, 8'hAB}) begin
        nfail++;
        $display("FAIL smux_ksa: wren=%0b addr=%0h data=%0h required 1/10/AB",
                 bus.s_wren, bus.s_address, bus.s_data);
      end
    end
    wait_cond(2, "smux_wait_prga", ok);
    if (ok) begin
      nchk++;
      if ({bus.s_wren, bus.s_address, bus.s_data} !== {1'b1, 8'h20, 8'hCD}) begin
        nfail++;
        $display("FAIL smux_prga: wren=%0b addr=%0h data=%0h required 1/20/CD",
                 bus.s_wren, bus.s_address, bus.s_data);
      end
    end
    // A start while busy must not restart the search.
    start_pulse();
    wait_cond(3, "smux_wait_chk", ok);
    if (ok) begin
      nchk++;
      if ({bus.s_wren, bus.s_address, bus.s_data, bus.dm_wren} !== 18'd0) begin
        nfail++;
        $display("FAIL smux_chk: s_wren=%0b s_addr=%0h s_data=%0h dm_wren=%0b required all 0",
                 bus.s_wren, bus.s_address, bus.s_data, bus.dm_wren);
      end
    end
    wait_result("smux");
  endtask

  task automatic test_boundaries();
    logic [7:0] vals [7];
    logic       acc  [7];
    int         poss [2];
    vals = '{8'h60, 8'h7B, 8'h1F, 8'h21, 8'h61, 8'h7A, 8'h20};
    acc  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    poss = '{0, 31};
    mode = 3;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 7; i++) begin
        bpos = poss[p];
        bval = vals[i];
        run_search($sformatf("bound_b%0d_%h", poss[p], vals[i]), 1'b1, 1'b0,
                   acc[i] ? 24'd0 : 24'd1, acc[i] ? 1 : 2);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    mode = 2;
    start_pulse();
    wait_cond(4, "rstmid_wait_prga", ok);
    reset = 1'b1;
    @(negedge clk);
    nchk++;
    if ({bus.init_start, bus.ksa_start, bus.prga_start, bus.s_wren, bus.dm_wren, bus.busy} !== 6'b0) begin
      nfail++;
      $display("FAIL rstmid_ctrl: starts/s_wren/dm_wren/busy=%b required 000000",
               {bus.init_start, bus.ksa_start, bus.prga_start, bus.s_wren, bus.dm_wren, bus.busy});
    end
    nchk++;
    if (bus.key_out !== 24'd0) begin
      nfail++;
      $display("FAIL rstmid_key: got %0h required 0", bus.key_out);
    end
    reset = 1'b0;
    mode = 0;
    push_exp(1'b1, 1'b0, 24'd0, 1);
    start_pulse();
    nchk++;
    if ({bus.sub_reset, bus.init_start} !== 2'b10) begin
      nfail++;
      $display("FAIL rstmid_subrst: sub_reset/init_start=%b required 10", {bus.sub_reset, bus.init_start});
    end
    @(negedge clk);
    nchk++;
    if ({bus.sub_reset, bus.init_start} !== 2'b01) begin
      nfail++;
      $display("FAIL rstmid_init: sub_reset/init_start=%b required 01", {bus.sub_reset, bus.init_start});
    end
    wait_result("rstmid");
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.init_s_addr = 8'h05; bus.init_s_data = 8'h11; bus.init_s_wren = 1'b1;
    bus.ksa_s_addr  = 8'h10; bus.ksa_s_data  = 8'hAB; bus.ksa_s_wren  = 1'b1;
    bus.prga_s_addr = 8'h20; bus.prga_s_data = 8'hCD; bus.prga_s_wren = 1'b1;
    test_reset();
    test_key0();
    test_retry();
    test_fail();
    test_s_mux();
    test_boundaries();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", nchk, nfail);
    $finish;
  end

endmodule
